regs_mp: RTL and testbench
==========================

REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH SHALL equal 2**ADDR_W registers.
REQ-003 Parameter ZERO_R0, 1, when 1 register 0 SHALL read as all-zeros and ignore writes.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Wr_en  in  1  write request for the current cycle.
REQ-007 Wr_addr  in  ADDR_W  write address.
REQ-008 Wr_data  in  DATA_W  write data.
REQ-009 Wr_be  in  DATA_W/8  byte enables; bit k covers Wr_data[8k+7:8k].
REQ-010 Rd_en_a / Rd_en_b  in  1 each  read requests, ports A and B.
REQ-011 Rd_addr_a / Rd_addr_b  in  ADDR_W each  read addresses.
REQ-012 Rd_data_a / Rd_data_b  out  DATA_W each  registered read data.
REQ-013 Rd_valid_a / Rd_valid_b  out  1 each  high for one cycle when the matching Rd_data holds a fresh result.
REQ-014 Clr_req  in  1  single-cycle pulse starting a sequential clear of all registers.
REQ-015 Busy  out  1  high while a clear is in progress.
REQ-016 Byte_sel  in  $clog2(DATA_W/8)  selects the byte of Rd_data_a shown on LED.
REQ-017 LED  out  8  registered display of Rd_data_a byte Byte_sel.

Function
REQ-018 Write: with Wr_en=1 and Busy=0, each byte k with Wr_be[k]=1 SHALL update at the edge; bytes with Wr_be[k]=0 SHALL keep their value.
REQ-019 Read latency: Rd_data_x and Rd_valid_x SHALL reflect the edge at which Rd_en_x=1 was sampled (1 cycle); with Rd_en_x=0, Rd_data_x SHALL hold and Rd_valid_x SHALL be 0.
REQ-020 Bypass: when a read and an accepted write target the same address in the same cycle, the read SHALL return the merged value (new bytes where Wr_be=1, old bytes elsewhere).
REQ-021 Both ports reading the same address in one cycle SHALL return identical data.
REQ-022 With ZERO_R0=1, reads of address 0 SHALL return 0, including under bypass.
REQ-023 Byte_sel values at or above DATA_W/8 SHALL display byte 0.
REQ-024 LED SHALL update every cycle from the current Rd_data_a and Byte_sel (1-cycle lag).
REQ-025 Clear FSM states: IDLE and CLEAR; IDLE->CLEAR on Clr_req=1; in CLEAR one register per cycle is zeroed, counter ascending 0..DEPTH-1; CLEAR->IDLE after address DEPTH-1 is zeroed.
REQ-026 Busy SHALL be 1 exactly for the DEPTH cycles spent in CLEAR, asserting the cycle after Clr_req is sampled.
REQ-027 During CLEAR, writes SHALL be dropped; reads SHALL proceed and return current contents (cleared entries read 0).
REQ-028 Clr_req while in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-029 Clr_req and Wr_en in the same IDLE cycle: the write SHALL complete, then the clear SHALL begin.

Reset
REQ-030 Reset=1 SHALL immediately zero all registers, Rd_data_a/b, Rd_valid_a/b, LED, Busy, and the clear counter, and force IDLE.
REQ-031 Reset asserted mid-clear SHALL abort the clear; after release the block SHALL be in IDLE with Busy=0.
REQ-032 Inputs SHALL be ignored while Reset=1; first accepted operation occurs at the first rising edge after deassertion.

Verification
REQ-033 Write addr 3 = 0x8000_1111, Wr_be=4'hF; next cycle read A addr 3 -> next cycle Rd_data_a=0x8000_1111, Rd_valid_a=1; Byte_sel=3 -> LED=0x80 one cycle later.
REQ-034 Addr 5 holds 0x7FFF_FFFF; write 0x0000_00AA with Wr_be=4'b0001 while port B reads addr 5 same cycle -> Rd_data_b=0x7FFF_FFAA.
REQ-035 ZERO_R0=1: write 0xFFFF_FFFF to addr 0, read both ports addr 0 -> both return 0x0000_0000.
REQ-036 Fill all 32 regs non-zero, pulse Clr_req -> Busy high exactly 32 cycles; write issued during Busy dropped; all reads afterward return 0.
REQ-037 Pulse Clr_req, assert Reset after 10 Busy cycles -> all outputs 0 immediately; after release Busy=0 and a write/read of addr 31 = 0x0000_0001 returns 0x0000_0001.
REQ-038 Rerun REQ-033 and REQ-034 with DATA_W=64, ADDR_W=4 -> identical behaviour with 8 byte lanes and 16 registers.

Source files
------------

// File: rtl/regs_mp_if.sv
// Bus bundle for the regs_mp multi-port register file.
// Handshake semantics: there is no ready/back-pressure. A write is taken
// on any rising edge where Wr_en=1 and Busy=0. A read request (Rd_en_x=1)
// is always taken, and Rd_valid_x pulses for exactly one cycle, one edge
// later, with Rd_data_x carrying the result.
interface regs_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NB    = DATA_W / 8;
  localparam int SEL_W = $clog2(NB);

  logic              Wr_en;
  logic [ADDR_W-1:0] Wr_addr;
  logic [DATA_W-1:0] Wr_data;
  logic [NB-1:0]     Wr_be;
  logic              Rd_en_a;
  logic              Rd_en_b;
  logic [ADDR_W-1:0] Rd_addr_a;
  logic [ADDR_W-1:0] Rd_addr_b;
  logic [DATA_W-1:0] Rd_data_a;
  logic [DATA_W-1:0] Rd_data_b;
  logic              Rd_valid_a;
  logic              Rd_valid_b;
  logic              Clr_req;
  logic              Busy;
  logic [SEL_W-1:0]  Byte_sel;
  logic [7:0]        LED;
  // 1 while the clear FSM is in CLEAR, 0 in IDLE
  logic              Dbg_state;

  modport master (
    output Wr_en, Wr_addr, Wr_data, Wr_be,
    output Rd_en_a, Rd_en_b, Rd_addr_a, Rd_addr_b,
    output Clr_req, Byte_sel,
    input  Rd_data_a, Rd_data_b, Rd_valid_a, Rd_valid_b,
    input  Busy, LED, Dbg_state
  );

  modport slave (
    input  Wr_en, Wr_addr, Wr_data, Wr_be,
    input  Rd_en_a, Rd_en_b, Rd_addr_a, Rd_addr_b,
    input  Clr_req, Byte_sel,
    output Rd_data_a, Rd_data_b, Rd_valid_a, Rd_valid_b,
    output Busy, LED, Dbg_state
  );
endinterface

// File: rtl/regs_mp.sv
// Register file with one byte-enabled write port, two registered read
// ports with write-to-read bypass, a sequential clear engine and a byte
// display of read port A.
module regs_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input logic     Clk,
  input logic     Reset,
  regs_mp_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int SEL_W = $clog2(NB);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              wr_to_r0;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_val_a;
  logic [DATA_W-1:0] rd_val_b;
  logic [7:0]        led_nxt;

  // Writes are only honoured while the clear engine is idle.
  assign wr_accept = bus.Wr_en && (state == IDLE);
  assign wr_to_r0  = (ZERO_R0 != 0) && (bus.Wr_addr == '0);

  assign bus.Busy      = (state == CLEAR);
  assign bus.Dbg_state = (state == CLEAR);

  // Merge enabled write bytes over the current contents of the target.
  always_comb begin
    wr_merged = mem[bus.Wr_addr];
    for (int k = 0; k < NB; k++) begin
      if (bus.Wr_be[k]) wr_merged[8*k +: 8] = bus.Wr_data[8*k +: 8];
    end
  end

  // Port A read value: array, overridden by a same-cycle write, forced to 0 for r0.
  always_comb begin
    rd_val_a = mem[bus.Rd_addr_a];
    if (wr_accept && (bus.Wr_addr == bus.Rd_addr_a)) rd_val_a = wr_merged;
    if ((ZERO_R0 != 0) && (bus.Rd_addr_a == '0)) rd_val_a = '0;
  end

  // Port B read value: same selection as port A so equal addresses agree.
  always_comb begin
    rd_val_b = mem[bus.Rd_addr_b];
    if (wr_accept && (bus.Wr_addr == bus.Rd_addr_b)) rd_val_b = wr_merged;
    if ((ZERO_R0 != 0) && (bus.Rd_addr_b == '0)) rd_val_b = '0;
  end

  // Clear FSM next-state: IDLE waits for Clr_req, CLEAR walks 0..DEPTH-1 once.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (bus.Clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        // Clr_req is deliberately not looked at here so a clear never restarts.
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (&clr_cnt) state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Clear FSM state and counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Register array: clear engine has priority; writes to r0 are dropped when hard-wired.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept && !wr_to_r0) begin
      mem[bus.Wr_addr] <= wr_merged;
    end
  end

  // Read port registers: data holds when no request, valid is a one-cycle strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.Rd_data_a  <= '0;
      bus.Rd_data_b  <= '0;
      bus.Rd_valid_a <= 1'b0;
      bus.Rd_valid_b <= 1'b0;
    end else begin
      bus.Rd_valid_a <= bus.Rd_en_a;
      bus.Rd_valid_b <= bus.Rd_en_b;
      if (bus.Rd_en_a) bus.Rd_data_a <= rd_val_a;
      if (bus.Rd_en_b) bus.Rd_data_b <= rd_val_b;
    end
  end

  // Byte picker for the display; any select with no matching lane shows byte 0.
  always_comb begin
    led_nxt = bus.Rd_data_a[7:0];
    for (int k = 1; k < NB; k++) begin
      if (bus.Byte_sel == SEL_W'(k)) led_nxt = bus.Rd_data_a[8*k +: 8];
    end
  end

  // Display register, refreshed every cycle from the current port A data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) bus.LED <= '0;
    else       bus.LED <= led_nxt;
  end
endmodule

// File: tb/tb_regs_mp.sv
// Bench for regs_mp: 32-bit/32-entry instance driven through a scoreboard,
// plus a 64-bit/16-entry instance exercised with directed vectors.
module tb_regs_mp;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  regs_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regs_mp_if #(.DATA_W(64), .ADDR_W(4)) wbus ();

  regs_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  regs_mp #(.DATA_W(64), .ADDR_W(4), .ZERO_R0(1)) dut_w (
    .Clk(Clk), .Reset(Reset), .bus(wbus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [32];
  logic [31:0] exp_qa [$];
  logic [31:0] exp_qb [$];
  logic [31:0] exp_a_v;
  logic [31:0] exp_b_v;
  logic [31:0] exp_rda;
  logic        exp_va;
  logic [7:0]  exp_led;
  logic        clr_active;
  int          clr_idx;
  int          busy_seen;
  logic [1:0]  sel;

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  // Scoreboard: pop the oldest expected read whenever a port reports valid.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.Rd_valid_a === 1'b1) begin
        vectors++;
        if (exp_qa.size() == 0) begin
          miscompares++;
          $display("FAIL rd_a_unexpected: got %h, expected no read", bus.Rd_data_a);
        end else begin
          exp_a_v = exp_qa.pop_front();
          if (bus.Rd_data_a !== exp_a_v) begin
            miscompares++;
            $display("FAIL rd_a_data: got %h, expected %h", bus.Rd_data_a, exp_a_v);
          end
        end
      end
      if (bus.Rd_valid_b === 1'b1) begin
        vectors++;
        if (exp_qb.size() == 0) begin
          miscompares++;
          $display("FAIL rd_b_unexpected: got %h, expected no read", bus.Rd_data_b);
        end else begin
          exp_b_v = exp_qb.pop_front();
          if (bus.Rd_data_b !== exp_b_v) begin
            miscompares++;
            $display("FAIL rd_b_data: got %h, expected %h", bus.Rd_data_b, exp_b_v);
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_rda = '0; exp_va = 1'b0; exp_led = '0;
    clr_active = 1'b0; clr_idx = 0;
  endtask

  task automatic zero_inputs();
    bus.Wr_en = 0; bus.Wr_addr = '0; bus.Wr_data = '0; bus.Wr_be = '0;
    bus.Rd_en_a = 0; bus.Rd_en_b = 0; bus.Rd_addr_a = '0; bus.Rd_addr_b = '0;
    bus.Clr_req = 0; bus.Byte_sel = '0;
    wbus.Wr_en = 0; wbus.Wr_addr = '0; wbus.Wr_data = '0; wbus.Wr_be = '0;
    wbus.Rd_en_a = 0; wbus.Rd_en_b = 0; wbus.Rd_addr_a = '0; wbus.Rd_addr_b = '0;
    wbus.Clr_req = 0; wbus.Byte_sel = '0;
  endtask

  // One clock of stimulus on the 32-bit instance, with model update.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic rea, input logic [4:0] aa, input logic reb, input logic [4:0] ab,
                       input logic clr);
    logic [31:0] merged, va, vb;
    logic accept;
    @(negedge Clk);
    if (bus.Busy === 1'b1) busy_seen++;
    vectors++;
    if (bus.Busy !== clr_active) begin
      miscompares++;
      $display("FAIL busy: got %b, expected %b", bus.Busy, clr_active);
    end
    vectors++;
    if (bus.LED !== exp_led) begin
      miscompares++;
      $display("FAIL led: got %h, expected %h", bus.LED, exp_led);
    end
    vectors++;
    if (bus.Rd_valid_a !== exp_va || bus.Rd_data_a !== exp_rda) begin
      miscompares++;
      $display("FAIL rd_a_state: got v=%b d=%h, expected v=%b d=%h", bus.Rd_valid_a, bus.Rd_data_a, exp_va, exp_rda);
    end
    bus.Wr_en = we; bus.Wr_addr = wa; bus.Wr_data = wd; bus.Wr_be = be;
    bus.Rd_en_a = rea; bus.Rd_addr_a = aa; bus.Rd_en_b = reb; bus.Rd_addr_b = ab;
    bus.Clr_req = clr; bus.Byte_sel = sel;
    accept = we && !clr_active;
    merged = merge32(model[wa], wd, be);
    va = (aa == 0) ? 32'h0 : ((accept && wa == aa) ? merged : model[aa]);
    vb = (ab == 0) ? 32'h0 : ((accept && wa == ab) ? merged : model[ab]);
    if (rea) exp_qa.push_back(va);
    if (reb) exp_qb.push_back(vb);
    exp_led = exp_rda[8*sel +: 8];
    exp_va = rea;
    if (rea) exp_rda = va;
    if (clr_active) begin
      model[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == 32) clr_active = 1'b0;
    end else begin
      if (accept && wa != 0) model[wa] = merged;
      if (clr) begin
        clr_active = 1'b1;
        clr_idx = 0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if (bus.Rd_data_a !== 0 || bus.Rd_data_b !== 0 || bus.Rd_valid_a !== 0 || bus.Rd_valid_b !== 0 ||
        bus.LED !== 0 || bus.Busy !== 0 || bus.Dbg_state !== 0) begin
      miscompares++;
      $display("FAIL %s: got da=%h db=%h va=%b vb=%b led=%h busy=%b st=%b, expected all 0", tag,
               bus.Rd_data_a, bus.Rd_data_b, bus.Rd_valid_a, bus.Rd_valid_b, bus.LED, bus.Busy, bus.Dbg_state);
    end
  endtask

  task automatic test_reset();
    zero_inputs();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    // Inputs toggling under reset must have no effect.
    bus.Wr_en = 1; bus.Wr_addr = 5'd9; bus.Wr_data = 32'hDEAD_BEEF; bus.Wr_be = 4'hF;
    bus.Rd_en_a = 1; bus.Rd_addr_a = 5'd9; bus.Clr_req = 1;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge Clk);
    zero_inputs();
    Reset = 1'b0;
    cycle(0, 0, 0, 0, 1, 5'd9, 1, 5'd9, 0);
    idle();
  endtask

  task automatic test_basic();
    sel = 2'd3;
    cycle(1, 5'd3, 32'h8000_1111, 4'hF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (bus.LED !== 8'h80) begin
      miscompares++;
      $display("FAIL basic_led: got %h, expected 80", bus.LED);
    end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      idle();
    end
  endtask

  task automatic test_bypass();
    sel = 2'd0;
    cycle(1, 5'd5, 32'h7FFF_FFFF, 4'hF, 0, 0, 0, 0, 0);
    cycle(1, 5'd5, 32'h0000_00AA, 4'b0001, 0, 0, 1, 5'd5, 0);
    idle();
    vectors++;
    if (bus.Rd_data_b !== 32'h7FFF_FFAA) begin
      miscompares++;
      $display("FAIL bypass_b: got %h, expected 7fffffaa", bus.Rd_data_b);
    end
    cycle(1, 5'd5, 32'h1200_0000, 4'b1000, 1, 5'd5, 1, 5'd5, 0);
    cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
    idle();
  endtask

  task automatic test_zero_r0();
    cycle(1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1, 5'd0, 1, 5'd0, 0);
    cycle(0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 0);
    idle();
    vectors++;
    if (bus.Rd_data_a !== 32'h0 || bus.Rd_data_b !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_r0: got a=%h b=%h, expected 0", bus.Rd_data_a, bus.Rd_data_b);
    end
  endtask

  task automatic test_random();
    logic [4:0] wa, aa, ab;
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      aa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 2) == 0) ? aa : 5'($urandom_range(0, 31));
      sel = 2'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), wa, $urandom(), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ab, 0);
    end
    idle();
  endtask

  task automatic test_clear();
    for (int a = 1; a < 32; a++) cycle(1, 5'(a), $urandom() | 32'h1, 4'hF, 0, 0, 0, 0, 0);
    busy_seen = 0;
    // Write and clear request together: the write lands first, then the clear walks over it.
    cycle(1, 5'd7, 32'h0000_1234, 4'hF, 0, 0, 0, 0, 1);
    for (int i = 0; i < 35; i++) begin
      cycle(1, 5'($urandom_range(1, 31)), 32'hFFFF_0000, 4'hF,
            1, (i == 0) ? 5'd7 : 5'($urandom_range(0, 31)), 1, 5'($urandom_range(0, 31)), (i == 5));
    end
    vectors++;
    if (busy_seen != 32) begin
      miscompares++;
      $display("FAIL busy_len: got %0d cycles, expected 32", busy_seen);
    end
    for (int a = 0; a < 32; a++) cycle(0, 0, 0, 0, 1, 5'(a), 1, 5'(31 - a), 0);
    idle();
  endtask

  task automatic test_reset_mid_clear();
    sel = 2'd0;
    cycle(1, 5'd31, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 5'd31, 1, 5'd31, 0);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_clear");
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    zero_inputs();
    Reset = 1'b0;
    cycle(1, 5'd31, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5'd31, 1, 5'd30, 0);
    idle();
    vectors++;
    if (bus.Rd_data_a !== 32'h1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort: got d=%h busy=%b, expected 00000001 / 0", bus.Rd_data_a, bus.Busy);
    end
  endtask

  task automatic test_wide();
    @(negedge Clk);
    wbus.Wr_en = 1; wbus.Wr_addr = 4'd3; wbus.Wr_data = 64'h8000_1111_2233_4455; wbus.Wr_be = 8'hFF;
    @(negedge Clk);
    wbus.Wr_en = 0; wbus.Rd_en_a = 1; wbus.Rd_addr_a = 4'd3; wbus.Byte_sel = 3'd7;
    @(negedge Clk);
    wbus.Rd_en_a = 0;
    vectors++;
    if (wbus.Rd_data_a !== 64'h8000_1111_2233_4455 || wbus.Rd_valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_read: got v=%b d=%h, expected 1 / 8000111122334455", wbus.Rd_valid_a, wbus.Rd_data_a);
    end
    @(negedge Clk);
    wbus.Byte_sel = 3'd3;
    vectors++;
    if (wbus.LED !== 8'h80 || wbus.Rd_valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL wide_led7: got led=%h v=%b, expected 80 / 0", wbus.LED, wbus.Rd_valid_a);
    end
    wbus.Wr_en = 1; wbus.Wr_addr = 4'd5; wbus.Wr_data = 64'h7FFF_FFFF_FFFF_FFFF; wbus.Wr_be = 8'hFF;
    @(negedge Clk);
    vectors++;
    if (wbus.LED !== 8'h22) begin
      miscompares++;
      $display("FAIL wide_led3: got %h, expected 22", wbus.LED);
    end
    wbus.Wr_data = 64'h0000_0000_0000_00AA; wbus.Wr_be = 8'h01;
    wbus.Rd_en_b = 1; wbus.Rd_addr_b = 4'd5;
    @(negedge Clk);
    wbus.Wr_en = 1; wbus.Wr_addr = 4'd0; wbus.Wr_data = '1; wbus.Wr_be = 8'hFF;
    wbus.Rd_en_b = 0; wbus.Rd_en_a = 1; wbus.Rd_addr_a = 4'd5;
    vectors++;
    if (wbus.Rd_data_b !== 64'h7FFF_FFFF_FFFF_FFAA || wbus.Rd_valid_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_bypass: got v=%b d=%h, expected 1 / 7fffffffffffffaa", wbus.Rd_valid_b, wbus.Rd_data_b);
    end
    @(negedge Clk);
    wbus.Wr_en = 0; wbus.Rd_en_a = 1; wbus.Rd_addr_a = 4'd0; wbus.Rd_en_b = 1; wbus.Rd_addr_b = 4'd0;
    vectors++;
    if (wbus.Rd_data_a !== 64'h7FFF_FFFF_FFFF_FFAA) begin
      miscompares++;
      $display("FAIL wide_stored: got %h, expected 7fffffffffffffaa", wbus.Rd_data_a);
    end
    @(negedge Clk);
    wbus.Rd_en_a = 0; wbus.Rd_en_b = 0;
    vectors++;
    if (wbus.Rd_data_a !== 64'h0 || wbus.Rd_data_b !== 64'h0) begin
      miscompares++;
      $display("FAIL wide_r0: got a=%h b=%h, expected 0", wbus.Rd_data_a, wbus.Rd_data_b);
    end
  endtask

  initial begin
    sel = 2'd0;
    busy_seen = 0;
    zero_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_bypass();
    test_zero_r0();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_wide();
    repeat (3) idle();
    vectors++;
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: got %0d/%0d outstanding, expected 0/0", exp_qa.size(), exp_qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
